// File: rtl/quiz_pkg.sv
// Shared constants for the arithmetic quiz engine: operator codes, FSM state
// encodings, 7-segment glyphs (abcdefg, 1 = lit) and the LFSR step function.
package quiz_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_GEN  = 3'd1;
    localparam logic [2:0] ST_SHOW = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_OVER = 3'd4;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// 4-bit digit to abcdefg segment decoder; codes 10..15 render blank.
module seg7_dec
    import quiz_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/quiz_game_core.sv
// Arithmetic quiz engine: LFSR operands/operator, multiplexed 7-segment display,
// score/lives/timeout tracking. Define QUIZ_DIV_EN to enable the divide operator.
module quiz_game_core
    import quiz_pkg::*;
#(
    parameter int          OPW            = 4,
    parameter int          MAX_OPND       = 9,
    parameter int          SHOW_CYCLES    = 4,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter int          LIVES          = 3,
    parameter int          SCORE_MAX      = 9,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           answer_valid,
    input  logic [1:0]     answer_op,
    output logic [6:0]     num_seg,
    output logic [1:0]     digit_sel,
    output logic [6:0]     score_seg,
    output logic [2:0]     lives_left,
    output logic           correct_p,
    output logic           wrong_p,
    output logic           game_over,
    output logic           won,
    output logic [OPW-1:0] cur_a,
    output logic [OPW-1:0] cur_b,
    output logic [1:0]     cur_op
);

    localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0]  SLOT_LAST = SW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [OPW-1:0] OPND_M    = OPW'(MAX_OPND);
    localparam logic [OPW-1:0] OPND_M1   = OPW'(MAX_OPND + 1);
    localparam logic [3:0]     SCORE_LIM = 4'(SCORE_MAX);
    localparam logic [2:0]     LIVES_INI = 3'(LIVES);

    logic [2:0]     state_q, state_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [OPW-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]     op_q, op_d;
    logic [6:0]     r_q, r_d;
    logic [3:0]     score_q, score_d;
    logic [2:0]     lives_q, lives_d;
    logic [1:0]     dsel_q, dsel_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic [TW-1:0]  to_q, to_d;
    logic [6:0]     num_seg_q, num_seg_d;
    logic           correct_q, correct_d, wrong_q, wrong_d, won_q, won_d;

    logic [OPW-1:0] raw_x, raw_y, red_x, red_y, gen_a, gen_b;
    logic [1:0]     gen_op;
    logic [6:0]     gen_r, ext_a, ext_b;
    logic [3:0]     dig;
    logic [6:0]     dig_seg;
    logic           hit, miss;

    // Operand/operator generation, only consumed in the GEN cycle.
    always_comb begin
        raw_x = lfsr_q[OPW-1:0];
        raw_y = lfsr_q[2*OPW-1:OPW];
        red_x = (raw_x > OPND_M) ? raw_x - OPND_M1 : raw_x;
        red_y = (raw_y > OPND_M) ? raw_y - OPND_M1 : raw_y;
        if (red_x >= red_y) begin
            gen_a = red_x;
            gen_b = red_y;
        end else begin
            gen_a = red_y;
            gen_b = red_x;
        end
        gen_op = lfsr_q[9:8];
`ifdef QUIZ_DIV_EN
        // Only a divide needs a non-zero divisor; other ops keep A >= B intact.
        if (gen_op == OP_DIV && gen_b == '0) gen_b = OPW'(1);
`else
        if (gen_op == OP_DIV) gen_op = OP_ADD;
`endif
        ext_a = 7'(gen_a);
        ext_b = 7'(gen_b);
        case (gen_op)
            OP_ADD:  gen_r = ext_a + ext_b;
            OP_SUB:  gen_r = ext_a - ext_b;
            OP_MUL:  gen_r = ext_a * ext_b;
`ifdef QUIZ_DIV_EN
            OP_DIV:  gen_r = ext_a / ext_b;
`endif
            default: gen_r = ext_a + ext_b;
        endcase
    end

    always_comb begin
        case (dsel_q)
            2'd0:    dig = 4'(a_q);
            2'd1:    dig = 4'(b_q);
            2'd2:    dig = 4'(r_q / 7'd10);
            default: dig = 4'(r_q % 7'd10);
        endcase
    end

    seg7_dec u_num_dec   (.digit(dig),     .seg(dig_seg));
    seg7_dec u_score_dec (.digit(score_q), .seg(score_seg));

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_step(lfsr_q);
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        r_d       = r_q;
        score_d   = score_q;
        lives_d   = lives_q;
        dsel_d    = dsel_q;
        slot_d    = slot_q;
        to_d      = to_q;
        correct_d = 1'b0;
        wrong_d   = 1'b0;
        won_d     = won_q;
        hit       = 1'b0;
        miss      = 1'b0;
        num_seg_d = (state_q == ST_SHOW || state_q == ST_WAIT) ? dig_seg : SEG_BLANK;

        if (state_q == ST_SHOW || state_q == ST_WAIT) begin
            if (slot_q == SLOT_LAST) begin
                slot_d = '0;
                dsel_d = dsel_q + 2'd1;
            end else begin
                slot_d = slot_q + SW'(1);
            end
        end

        case (state_q)
            ST_IDLE, ST_OVER: begin
                dsel_d = 2'd0;
                slot_d = '0;
                if (start) begin
                    state_d = ST_GEN;
                    score_d = 4'd0;
                    lives_d = LIVES_INI;
                    won_d   = 1'b0;
                end
            end
            ST_GEN: begin
                a_d     = gen_a;
                b_d     = gen_b;
                op_d    = gen_op;
                r_d     = gen_r;
                dsel_d  = 2'd0;
                slot_d  = '0;
                state_d = ST_SHOW;
            end
            ST_SHOW: begin
                to_d = '0;
                if (slot_q == SLOT_LAST && dsel_q == 2'd3) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                to_d = to_q + TW'(1);
                // An answer on the expiry cycle takes precedence over the timeout.
                if (answer_valid) begin
                    hit  = (answer_op == op_q);
                    miss = (answer_op != op_q);
                end else if (to_q == TO_LAST) begin
                    miss = 1'b1;
                end
                if (hit || miss) begin
                    correct_d = hit;
                    wrong_d   = miss;
                    if (hit && score_q != SCORE_LIM) score_d = score_q + 4'd1;
                    if (miss && lives_q != 3'd0) lives_d = lives_q - 3'd1;
                    if (score_d == SCORE_LIM) begin
                        state_d = ST_OVER;
                        won_d   = 1'b1;
                    end else if (lives_d == 3'd0) begin
                        state_d = ST_OVER;
                        won_d   = 1'b0;
                    end else begin
                        state_d = ST_GEN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= LFSR_SEED;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 2'd0;
            r_q       <= 7'd0;
            score_q   <= 4'd0;
            lives_q   <= LIVES_INI;
            dsel_q    <= 2'd0;
            slot_q    <= '0;
            to_q      <= '0;
            num_seg_q <= SEG_BLANK;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            won_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            r_q       <= r_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            dsel_q    <= dsel_d;
            slot_q    <= slot_d;
            to_q      <= to_d;
            num_seg_q <= num_seg_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            won_q     <= won_d;
        end
    end

    assign num_seg    = num_seg_q;
    assign digit_sel  = dsel_q;
    assign lives_left = lives_q;
    assign correct_p  = correct_q;
    assign wrong_p    = wrong_q;
    assign game_over  = (state_q == ST_OVER);
    assign won        = won_q;
    assign cur_a      = a_q;
    assign cur_b      = b_q;
    assign cur_op     = op_q;

endmodule

// File: tb/tb_quiz_game_core.sv
// Directed bench for quiz_game_core: predicts operands from an independent LFSR
// model and checks display sequence, scoring, lives, timeout and reset behaviour.
module tb_quiz_game_core;

  localparam int SC = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       answer_valid = 1'b0;
  logic [1:0] answer_op = 2'd0;
  logic [6:0] num_seg, score_seg;
  logic [1:0] digit_sel, cur_op;
  logic [2:0] lives_left;
  logic       correct_p, wrong_p, game_over, won;
  logic [3:0] cur_a, cur_b;

  int total = 0;
  int bad = 0;
  int exp_score, exp_lives;
  logic [15:0] m_lfsr, gen_lfsr;
  logic [6:0] exp_q[$];

  quiz_game_core #(
    .OPW(4), .MAX_OPND(9), .SHOW_CYCLES(SC), .TIMEOUT_CYCLES(TO),
    .LIVES(3), .SCORE_MAX(9), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .answer_valid(answer_valid),
    .answer_op(answer_op), .num_seg(num_seg), .digit_sel(digit_sel),
    .score_seg(score_seg), .lives_left(lives_left), .correct_p(correct_p),
    .wrong_p(wrong_p), .game_over(game_over), .won(won), .cur_a(cur_a),
    .cur_b(cur_b), .cur_op(cur_op)
  );

  // clock/reset block
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic void predict(input logic [15:0] l, output int a, output int b,
                                  output int op, output int r);
    int x = int'(l[3:0]);
    int y = int'(l[7:4]);
    if (x > 9) x -= 10;
    if (y > 9) y -= 10;
    a = (x > y) ? x : y;
    b = (x > y) ? y : x;
    op = int'(l[9:8]);
    if (op == 3) op = 0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      default: r = a * b;
    endcase
  endfunction

  // driver: begin a game; leaves the bench at the negedge of the GEN cycle
  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    gen_lfsr = m_lfsr;
    exp_score = 0;
    exp_lives = 3;
    check("start_lives", lives_left, 3);
    check("start_score", score_seg, seg_of(0));
    check("start_over", game_over, 0);
  endtask

  // driver: one question. mode 0 correct, 1 wrong, 2 timeout, 3 correct on expiry cycle
  task automatic play_round(input int mode);
    int a, b, op, r, early;
    logic hit;
    predict(gen_lfsr, a, b, op, r);
    @(negedge clk);
    check("pulse_clear", {correct_p, wrong_p}, 0);
    check("cur_a", cur_a, a);
    check("cur_b", cur_b, b);
    check("cur_op", cur_op, op);
    exp_q = {};
    for (int d = 0; d < 4; d++) begin
      for (int s = 0; s < SC; s++) begin
        case (d)
          0: exp_q.push_back(seg_of(a));
          1: exp_q.push_back(seg_of(b));
          2: exp_q.push_back(seg_of(r / 10));
          default: exp_q.push_back(seg_of(r % 10));
        endcase
      end
    end
    for (int k = 0; k < 4 * SC; k++) begin
      check("digit_sel", digit_sel, k / SC);
      if (k == 3) begin
        answer_valid = 1'b1;
        answer_op = 2'(op);
      end
      @(negedge clk);
      answer_valid = 1'b0;
      check("num_seg", num_seg, exp_q.pop_front());
      if (k == 3) check("show_ignores_answer", {correct_p, wrong_p}, 0);
    end
    hit = 1'b0;
    early = 0;
    case (mode)
      0: begin
        answer_valid = 1'b1; answer_op = 2'(op);
        @(negedge clk);
        answer_valid = 1'b0; hit = 1'b1;
      end
      1: begin
        answer_valid = 1'b1; answer_op = 2'(op + 1);
        @(negedge clk);
        answer_valid = 1'b0;
      end
      2: begin
        for (int i = 0; i < TO - 1; i++) begin
          @(negedge clk);
          if (correct_p || wrong_p) early++;
        end
        check("timeout_early", early, 0);
        @(negedge clk);
      end
      default: begin
        repeat (TO - 1) @(negedge clk);
        answer_valid = 1'b1; answer_op = 2'(op);
        @(negedge clk);
        answer_valid = 1'b0; hit = 1'b1;
      end
    endcase
    check("correct_p", correct_p, hit);
    check("wrong_p", wrong_p, !hit);
    if (hit && exp_score < 9) exp_score++;
    if (!hit && exp_lives > 0) exp_lives--;
    check("score_seg", score_seg, seg_of(exp_score));
    check("lives_left", lives_left, exp_lives);
    check("game_over", game_over, (exp_score == 9) || (exp_lives == 0));
    check("won", won, exp_score == 9);
    gen_lfsr = m_lfsr;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_score_seg", score_seg, 7'b1111110);
    check("idle_num_seg", num_seg, 0);
    check("idle_lives", lives_left, 3);
    check("idle_pulses", {correct_p, wrong_p}, 0);
    check("idle_over_won", {game_over, won}, 0);
    check("idle_digit_sel", digit_sel, 0);
    check("idle_operands", {cur_a, cur_b, cur_op}, 0);

    // winning game, fifth answer lands on the timeout expiry cycle
    start_game();
    for (int i = 0; i < 9; i++) play_round((i == 4) ? 3 : 0);
    @(negedge clk);
    check("over_blank", num_seg, 0);
    answer_valid = 1'b1; answer_op = 2'd0;
    @(negedge clk);
    answer_valid = 1'b0;
    check("over_ignores_answer", {correct_p, wrong_p}, 0);
    check("over_score_frozen", score_seg, seg_of(9));
    check("over_won_held", {game_over, won}, 2'b11);

    // losing game: wrong, timeout, wrong
    start_game();
    play_round(1);
    play_round(2);
    play_round(1);
    @(negedge clk);
    check("lost_pulses_clear", {correct_p, wrong_p}, 0);
    check("lost_state", {game_over, won}, 2'b10);

    // reset in the middle of SHOW
    start_game();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_num_seg", num_seg, 0);
    check("rst_digit_sel", digit_sel, 0);
    check("rst_operands", {cur_a, cur_b, cur_op}, 0);
    check("rst_pulses", {correct_p, wrong_p}, 0);
    check("rst_over", {game_over, won}, 0);
    check("rst_lives", lives_left, 3);
    check("rst_score", score_seg, seg_of(0));
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_stays_idle", num_seg, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
